// File: rtl/exe_mdu_iter_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// The issue side drives the request and accepts the result; the unit is the slave.
interface exe_mdu_iter_if #(
   parameter int XLEN = 32,
   parameter int RDW  = 5
) ();
   logic            req_val;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic [RDW-1:0]  req_rd;
   logic            resp_val;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic [RDW-1:0]  resp_rd;

   modport master (
      output req_val, req_op, req_a, req_b, req_rd, resp_ready,
      input  req_ready, resp_val, resp_data, resp_rd
   );

   modport slave (
      input  req_val, req_op, req_a, req_b, req_rd, resp_ready,
      output req_ready, resp_val, resp_data, resp_rd
   );
endinterface

// File: rtl/exe_mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// UNROLL bits per CALC cycle, result held with its rd tag until accepted.
module exe_mdu_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1,
   parameter int RDW    = 5
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic           flush,
   exe_mdu_iter_if.slave  mdu,
   output logic           busy
);
   localparam int STEPS = XLEN / UNROLL;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0]   LAST    = CW'(STEPS - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state_q, state_d;

   logic [2:0]        op_q;
   logic [RDW-1:0]    rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   dsor_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_nx;
   logic [CW-1:0]     cnt_q;
   logic [XLEN-1:0]   data_q;

   logic            fire, is_div, is_rem;
   logic            a_sgn, b_sgn, a_neg, b_neg, neg_d;
   logic            div_zero, ovf, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_val, fix_res;

   assign mdu.req_ready = (state_q == IDLE) && !flush;
   assign fire          = mdu.req_val && mdu.req_ready;
   assign busy          = state_q != IDLE;
   assign mdu.resp_val  = state_q == DONE;
   assign mdu.resp_data = data_q;
   assign mdu.resp_rd   = rd_q;

   // Operand decode and the special cases that skip iteration
   always_comb begin
      is_div   = mdu.req_op[2];
      is_rem   = mdu.req_op[2] & mdu.req_op[1];
      a_sgn    = is_div ? !mdu.req_op[0] : (mdu.req_op[1:0] != 2'd3);
      b_sgn    = is_div ? !mdu.req_op[0] : !mdu.req_op[1];
      a_neg    = a_sgn & mdu.req_a[XLEN-1];
      b_neg    = b_sgn & mdu.req_b[XLEN-1];
      a_mag    = a_neg ? -mdu.req_a : mdu.req_a;
      b_mag    = b_neg ? -mdu.req_b : mdu.req_b;
      neg_d    = is_rem ? a_neg : (a_neg ^ b_neg);
      div_zero = is_div && (mdu.req_b == '0);
      ovf      = is_div && !mdu.req_op[0] &&
                 (mdu.req_a == MIN_INT) && (mdu.req_b == '1);
      special  = div_zero || ovf;
      spec_val = '0;
      if (div_zero)
         spec_val = is_rem ? mdu.req_a : '1;
      else if (!is_rem)
         spec_val = MIN_INT;
   end

   logic [XLEN:0]   rem_t;
   logic [XLEN:0]   sum_t;
   logic [XLEN-1:0] diff_t;
   logic            ge_t;

   // acc = {hi, lo}: multiply keeps partial product / multiplier,
   // divide keeps partial remainder / dividend-then-quotient
   always_comb begin
      acc_nx = acc_q;
      rem_t  = '0;
      sum_t  = '0;
      diff_t = '0;
      ge_t   = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            rem_t  = {acc_nx[2*XLEN-1:XLEN], acc_nx[XLEN-1]};
            ge_t   = rem_t >= {1'b0, dsor_q};
            diff_t = rem_t[XLEN-1:0] - dsor_q;
            acc_nx = {ge_t ? diff_t : rem_t[XLEN-1:0],
                      acc_nx[XLEN-2:0], ge_t};
         end else begin
            sum_t  = {1'b0, acc_nx[2*XLEN-1:XLEN]} +
                     {1'b0, (acc_nx[0] ? dsor_q : {XLEN{1'b0}})};
            acc_nx = {sum_t, acc_nx[XLEN-1:1]};
         end
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   hi, lo;

   always_comb begin
      prod    = neg_q ? -acc_q : acc_q;
      hi      = acc_q[2*XLEN-1:XLEN];
      lo      = acc_q[XLEN-1:0];
      fix_res = '0;
      if (op_q[2])
         fix_res = op_q[1] ? (neg_q ? -hi : hi) : (neg_q ? -lo : lo);
      else if (op_q[1:0] == 2'd0)
         fix_res = prod[XLEN-1:0];
      else
         fix_res = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (fire) state_d = special ? DONE : CALC;
         CALC: if (cnt_q == LAST) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (mdu.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_q   <= '0;
         rd_q   <= '0;
         neg_q  <= 1'b0;
         dsor_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (fire) begin
               op_q   <= mdu.req_op;
               rd_q   <= mdu.req_rd;
               neg_q  <= neg_d;
               dsor_q <= is_div ? b_mag : a_mag;
               acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
               cnt_q  <= '0;
               if (special)
                  data_q <= spec_val;
            end
            CALC: begin
               acc_q <= acc_nx;
               if (cnt_q != LAST)
                  cnt_q <= cnt_q + 1'b1;
            end
            FIX:  data_q <= fix_res;
            DONE: if (mdu.resp_ready) begin
               data_q <= '0;
               rd_q   <= '0;
            end
            default: ;
         endcase
         if (flush) begin
            data_q <= '0;
            rd_q   <= '0;
         end
      end
   end
endmodule
